// File: rtl/body_bias_sequencer.sv
// rtl/body_bias_sequencer.sv - body-bias handshake sequencer between fast and low-leakage modes
// Optional BB_ACK_TIMEOUT_EN: bounds the bias_ack wait and traps into a sticky ERROR state.
module body_bias_sequencer #(
  parameter int IDLE_THRESH   = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int ACK_TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        dp_busy,
  input  logic        force_fast,
  input  logic        bias_ack,
  output logic        dp_ready,
  output logic        bias_req,
  output logic        bias_mode,
  output logic        lowleak_active,
  output logic [2:0]  state_o,
  output logic [15:0] sleep_cnt,
  output logic        err_timeout
);

  typedef enum logic [2:0] {
    ACTIVE       = 3'd0,
    ENTER_REQ    = 3'd1,
    ENTER_SETTLE = 3'd2,
    LOWLEAK      = 3'd3,
    EXIT_REQ     = 3'd4,
    EXIT_SETTLE  = 3'd5,
    ERROR        = 3'd6
  } state_e;

`ifdef BB_ACK_TIMEOUT_EN
  localparam logic TIMEOUT_EN = 1'b1;
`else
  localparam logic TIMEOUT_EN = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]  settle_cnt_q, settle_cnt_d;
  logic [15:0] ack_cnt_q, ack_cnt_d;
  logic        wake_pend_q, wake_pend_d;
  logic [15:0] sleep_cnt_q, sleep_cnt_d;
  logic        err_timeout_q, err_timeout_d;
  logic        dp_ready_q, dp_ready_d;
  logic        bias_req_q, bias_req_d;
  logic        bias_mode_q, bias_mode_d;
  logic        lowleak_q, lowleak_d;

  logic idle, wake, settle_done, ack_expired;

  assign idle        = !req_valid && !dp_busy && !force_fast;
  assign wake        = req_valid || force_fast;
  assign settle_done = (settle_cnt_q == 8'(SETTLE_CYCLES - 1));
  assign ack_expired = TIMEOUT_EN && (ack_cnt_q == 16'(ACK_TIMEOUT - 1));

  // Counters default to zero so each one clears on entry to the state that uses it.
  always_comb begin
    state_d      = state_q;
    idle_cnt_d   = '0;
    settle_cnt_d = '0;
    ack_cnt_d    = '0;
    wake_pend_d  = wake_pend_q;
    sleep_cnt_d  = sleep_cnt_q;
    case (state_q)
      ACTIVE: begin
        if (idle) begin
          if (idle_cnt_q == 16'(IDLE_THRESH - 1)) state_d = ENTER_REQ;
          else idle_cnt_d = idle_cnt_q + 16'd1;
        end
      end
      ENTER_REQ, EXIT_REQ: begin
        if (state_q == ENTER_REQ && wake) wake_pend_d = 1'b1;
        if (bias_ack) state_d = (state_q == ENTER_REQ) ? ENTER_SETTLE : EXIT_SETTLE;
        else if (ack_expired) state_d = ERROR;
        else ack_cnt_d = ack_cnt_q + 16'd1;
      end
      ENTER_SETTLE, EXIT_SETTLE: begin
        if (state_q == ENTER_SETTLE && wake) wake_pend_d = 1'b1;
        if (settle_done) begin
          if (state_q == ENTER_SETTLE) begin
            state_d     = LOWLEAK;
            sleep_cnt_d = sleep_cnt_q + 16'd1;
          end else begin
            state_d = ACTIVE;
          end
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      LOWLEAK: begin
        if (wake || wake_pend_q) begin
          state_d     = EXIT_REQ;
          wake_pend_d = 1'b0;
        end
      end
      default: state_d = state_q;
    endcase

    dp_ready_d    = (state_d == ACTIVE) || (state_d == ERROR);
    bias_req_d    = (state_d == ENTER_REQ) || (state_d == EXIT_REQ);
    bias_mode_d   = (state_d == ENTER_REQ) || (state_d == ENTER_SETTLE) || (state_d == LOWLEAK);
    lowleak_d     = (state_d == LOWLEAK);
    err_timeout_d = err_timeout_q || (TIMEOUT_EN && (state_d == ERROR));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ACTIVE;
      idle_cnt_q    <= '0;
      settle_cnt_q  <= '0;
      ack_cnt_q     <= '0;
      wake_pend_q   <= 1'b0;
      sleep_cnt_q   <= '0;
      err_timeout_q <= 1'b0;
      dp_ready_q    <= 1'b1;
      bias_req_q    <= 1'b0;
      bias_mode_q   <= 1'b0;
      lowleak_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idle_cnt_q    <= idle_cnt_d;
      settle_cnt_q  <= settle_cnt_d;
      ack_cnt_q     <= ack_cnt_d;
      wake_pend_q   <= wake_pend_d;
      sleep_cnt_q   <= sleep_cnt_d;
      err_timeout_q <= err_timeout_d;
      dp_ready_q    <= dp_ready_d;
      bias_req_q    <= bias_req_d;
      bias_mode_q   <= bias_mode_d;
      lowleak_q     <= lowleak_d;
    end
  end

  assign dp_ready       = dp_ready_q;
  assign bias_req       = bias_req_q;
  assign bias_mode      = bias_mode_q;
  assign lowleak_active = lowleak_q;
  assign state_o        = state_q;
  assign sleep_cnt      = sleep_cnt_q;
  assign err_timeout    = err_timeout_q;

endmodule
